servo_feed_ctrl: RTL and testbench

SERVO_FEED_CTRL -- requirements
Module: servo_feed_ctrl

---
 rtl/servo_feed_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_servo_feed_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_feed_ctrl.sv
// Z-axis servo feed controller: samples discharge pulse statistics on a fixed
// evaluation interval and issues retract/feed step bursts to the servo driver.
module servo_feed_ctrl #(
  parameter logic        [31:0] EVAL_PERIOD   = 32'd100000,
  parameter logic        [15:0] DIR_SETUP     = 16'd50,
  parameter logic        [15:0] STEP_HIGH     = 16'd100,
  parameter logic        [15:0] STEP_LOW      = 16'd400,
  parameter logic        [7:0]  SHORT_LIMIT   = 8'd20,
  parameter logic        [7:0]  ARC_LIMIT     = 8'd30,
  parameter logic        [7:0]  OPEN_LIMIT    = 8'd50,
  parameter logic        [7:0]  RETRACT_STEPS = 8'd16,
  parameter logic        [7:0]  FEED_STEPS    = 8'd2,
  parameter logic signed [15:0] POS_MAX       = 16'sd30000,
  parameter logic signed [15:0] POS_MIN       = -16'sd30000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                rate_valid,
  input  logic [7:0]          normal_rate,
  input  logic [7:0]          arc_rate,
  input  logic [7:0]          open_rate,
  input  logic [7:0]          short_rate,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                retracting,
  output logic signed [15:0]  position
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EVAL    = 3'd1;
  localparam logic [2:0] S_DIR_SET = 3'd2;
  localparam logic [2:0] S_STEP_HI = 3'd3;
  localparam logic [2:0] S_STEP_LO = 3'd4;

  logic [2:0]  state, state_n;
  logic [31:0] eval_cnt;
  logic        tick;
  logic [15:0] phase_cnt, phase_n;
  logic [7:0]  step_cnt, steps_n;
  logic        dir_n, retract_n, step_n;
  logic signed [15:0] pos_n;

  logic [7:0] normal_p0, arc_p0, open_p0, short_p0;
  logic [7:0] arc_p1, open_p1, short_p1;

  // Normal rate is kept with the others but does not steer the servo.
  logic unused_normal;
  assign unused_normal = ^normal_p0;

  function automatic logic step_blocked(input logic signed [15:0] pos, input logic d);
    return d ? (pos >= POS_MAX) : (pos <= POS_MIN);
  endfunction

  function automatic logic signed [15:0] step_pos(input logic signed [15:0] pos, input logic d);
    return d ? (pos + 16'sd1) : (pos - 16'sd1);
  endfunction

  // Stage p0: holding registers follow rate_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      normal_p0 <= '0;
      arc_p0    <= '0;
      open_p0   <= '0;
      short_p0  <= '0;
    end else if (rate_valid) begin
      normal_p0 <= normal_rate;
      arc_p0    <= arc_rate;
      open_p0   <= open_rate;
      short_p0  <= short_rate;
    end
  end

  // Stage p1: snapshot at the tick so a coincident rate_valid lands one interval later.
  always_ff @(posedge clk) begin
    if (rst) begin
      arc_p1   <= '0;
      open_p1  <= '0;
      short_p1 <= '0;
    end else if (tick && state == S_IDLE) begin
      arc_p1   <= arc_p0;
      open_p1  <= open_p0;
      short_p1 <= short_p0;
    end
  end

  assign tick = enable && (eval_cnt == EVAL_PERIOD - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || !enable)
      eval_cnt <= '0;
    else if (eval_cnt == EVAL_PERIOD - 32'd1)
      eval_cnt <= '0;
    else
      eval_cnt <= eval_cnt + 32'd1;
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase_cnt;
    steps_n   = step_cnt;
    dir_n     = dir;
    retract_n = retracting;
    step_n    = step;
    pos_n     = position;
    case (state)
      S_IDLE: if (tick) state_n = S_EVAL;
      S_EVAL: begin
        phase_n = '0;
        if (short_p1 >= SHORT_LIMIT) begin
          state_n   = S_DIR_SET;
          dir_n     = 1'b0;
          steps_n   = RETRACT_STEPS;
          retract_n = 1'b1;
        end else if (arc_p1 >= ARC_LIMIT) begin
          state_n = S_DIR_SET;
          dir_n   = 1'b0;
          steps_n = 8'd1;
        end else if (open_p1 >= OPEN_LIMIT) begin
          state_n = S_DIR_SET;
          dir_n   = 1'b1;
          steps_n = FEED_STEPS;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DIR_SET: begin
        if (!enable) begin
          state_n   = S_IDLE;
          retract_n = 1'b0;
        end else if (phase_cnt == DIR_SETUP - 16'd1) begin
          phase_n = '0;
          if (step_blocked(position, dir)) begin
            state_n   = S_IDLE;
            retract_n = 1'b0;
          end else begin
            state_n = S_STEP_HI;
            step_n  = 1'b1;
            pos_n   = step_pos(position, dir);
          end
        end else begin
          phase_n = phase_cnt + 16'd1;
        end
      end
      S_STEP_HI: begin
        // Pulse always runs to full width; enable is only honoured after STEP_LO.
        if (phase_cnt == STEP_HIGH - 16'd1) begin
          state_n = S_STEP_LO;
          step_n  = 1'b0;
          phase_n = '0;
        end else begin
          phase_n = phase_cnt + 16'd1;
        end
      end
      S_STEP_LO: begin
        if (phase_cnt == STEP_LOW - 16'd1) begin
          phase_n = '0;
          steps_n = step_cnt - 8'd1;
          if (!enable || step_cnt <= 8'd1 || step_blocked(position, dir)) begin
            state_n   = S_IDLE;
            retract_n = 1'b0;
          end else begin
            state_n = S_STEP_HI;
            step_n  = 1'b1;
            pos_n   = step_pos(position, dir);
          end
        end else begin
          phase_n = phase_cnt + 16'd1;
        end
      end
      default: begin
        state_n   = S_IDLE;
        step_n    = 1'b0;
        retract_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      step_cnt   <= '0;
      dir        <= 1'b0;
      retracting <= 1'b0;
      step       <= 1'b0;
      position   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      phase_cnt  <= phase_n;
      step_cnt   <= steps_n;
      dir        <= dir_n;
      retracting <= retract_n;
      step       <= step_n;
      position   <= pos_n;
      busy       <= (state_n == S_DIR_SET) || (state_n == S_STEP_HI) || (state_n == S_STEP_LO);
    end
  end

endmodule

// File: tb/tb_servo_feed_ctrl.sv
// Directed bench for servo_feed_ctrl with shortened timing; a second instance
// with POS_MAX=1 exercises the soft travel limit.
module tb_servo_feed_ctrl;

  localparam int STEP_HIGH = 10;
  localparam int STEP_LOW  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic en_lim = 1'b0;
  logic rate_valid = 1'b0;
  logic [7:0] normal_rate = '0, arc_rate = '0, open_rate = '0, short_rate = '0;

  logic step, dir, busy, retracting;
  logic signed [15:0] position;
  logic lim_step, lim_dir, lim_busy, lim_retracting;
  logic signed [15:0] lim_position;

  int n_chk = 0;
  int n_err = 0;

  int b_pulses, b_hi_bad, b_lo_bad, b_busy_cyc, b_retr_cyc, b_dir_chg;
  logic b_first_dir, b_started;

  always #5 clk = ~clk;

  servo_feed_ctrl #(
    .EVAL_PERIOD(32'd1000), .DIR_SETUP(16'd5), .STEP_HIGH(16'd10),
    .STEP_LOW(16'd40), .RETRACT_STEPS(8'd4)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .rate_valid(rate_valid),
    .normal_rate(normal_rate), .arc_rate(arc_rate), .open_rate(open_rate),
    .short_rate(short_rate), .step(step), .dir(dir), .busy(busy),
    .retracting(retracting), .position(position)
  );

  servo_feed_ctrl #(
    .EVAL_PERIOD(32'd1000), .DIR_SETUP(16'd5), .STEP_HIGH(16'd10),
    .STEP_LOW(16'd40), .RETRACT_STEPS(8'd4), .POS_MAX(16'sd1)
  ) u_lim (
    .clk(clk), .rst(rst), .enable(en_lim), .rate_valid(rate_valid),
    .normal_rate(normal_rate), .arc_rate(arc_rate), .open_rate(open_rate),
    .short_rate(short_rate), .step(lim_step), .dir(lim_dir), .busy(lim_busy),
    .retracting(lim_retracting), .position(lim_position)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    en_lim = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_rates(input logic [7:0] n, input logic [7:0] a, input logic [7:0] o, input logic [7:0] s);
    @(negedge clk);
    normal_rate = n;
    arc_rate    = a;
    open_rate   = o;
    short_rate  = s;
    rate_valid  = 1'b1;
    @(negedge clk);
    rate_valid  = 1'b0;
  endtask

  // Waits for the next burst on u_dut and measures it; drop_pulse>0 drops
  // enable three cycles into that pulse number.
  task automatic wait_burst(input int drop_pulse);
    int guard, hi_run, lo_run;
    logic prev_step, prev_dir;
    b_pulses = 0; b_hi_bad = 0; b_lo_bad = 0; b_busy_cyc = 0;
    b_retr_cyc = 0; b_dir_chg = 0; b_started = 1'b0; b_first_dir = 1'b0;
    hi_run = 0; lo_run = 0;
    guard = 0;
    while (!busy && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    if (!busy) return;
    b_started = 1'b1;
    b_first_dir = dir;
    prev_dir = dir;
    prev_step = 1'b0;
    guard = 0;
    while (busy && guard < 1000) begin
      b_busy_cyc++;
      if (retracting) b_retr_cyc++;
      if (dir != prev_dir) b_dir_chg++;
      prev_dir = dir;
      if (step) begin
        if (!prev_step) begin
          b_pulses++;
          if (b_pulses > 1 && lo_run != STEP_LOW) b_lo_bad++;
          lo_run = 0;
          hi_run = 0;
        end
        hi_run++;
        if (drop_pulse != 0 && b_pulses == drop_pulse && hi_run == 3) enable = 1'b0;
      end else begin
        if (prev_step && hi_run != STEP_HIGH) b_hi_bad++;
        if (b_pulses > 0) lo_run++;
      end
      prev_step = step;
      @(negedge clk);
      guard++;
    end
    check("burst_ends", busy, 0);
    if (b_pulses > 0 && lo_run != STEP_LOW) b_lo_bad++;
  endtask

  task automatic check_burst(input string tag, input int pulses, input int dir_exp,
                             input int busy_cyc, input int retr_cyc);
    check({tag, "_started"}, b_started, 1);
    check({tag, "_pulses"}, b_pulses, pulses);
    check({tag, "_hi_width"}, b_hi_bad, 0);
    check({tag, "_lo_width"}, b_lo_bad, 0);
    check({tag, "_dir"}, b_first_dir, dir_exp);
    check({tag, "_dir_stable"}, b_dir_chg, 0);
    check({tag, "_busy_cycles"}, b_busy_cyc, busy_cyc);
    check({tag, "_retracting"}, b_retr_cyc, retr_cyc);
  endtask

  initial begin
    int lim_rises, lim_busy_cyc, guard;
    logic lim_prev;

    // Reset state
    @(negedge clk);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_retracting", retracting, 0);
    check("rst_position", position, 0);
    rst = 1'b0;

    // Short-circuit retract
    do_reset();
    set_rates(8'd0, 8'd0, 8'd0, 8'd25);
    enable = 1'b1;
    wait_burst(0);
    check_burst("short", 4, 0, 205, 205);
    check("short_position", position, -4);
    check("short_retract_clear", retracting, 0);

    // Open-circuit feed over three ticks
    do_reset();
    set_rates(8'd0, 8'd0, 8'd60, 8'd0);
    enable = 1'b1;
    wait_burst(0);
    check_burst("feed1", 2, 1, 105, 0);
    check("feed1_position", position, 2);
    wait_burst(0);
    wait_burst(0);
    check("feed3_pulses", b_pulses, 2);
    check("feed3_position", position, 6);

    // Priority: short wins over arc and open
    do_reset();
    set_rates(8'd0, 8'd40, 8'd60, 8'd25);
    enable = 1'b1;
    wait_burst(0);
    check_burst("prio", 4, 0, 205, 205);
    check("prio_position", position, -4);
    set_rates(8'd100, 8'd0, 8'd0, 8'd0);
    wait_burst(0);
    check("normal_no_burst", b_started, 0);
    check("normal_position", position, -4);
    set_rates(8'd0, 8'd40, 8'd60, 8'd0);
    wait_burst(0);
    check_burst("arc", 1, 0, 55, 0);
    check("arc_position", position, -5);

    // Enable drop during the second pulse
    do_reset();
    set_rates(8'd0, 8'd0, 8'd0, 8'd25);
    enable = 1'b1;
    wait_burst(2);
    check_burst("drop", 2, 0, 105, 105);
    check("drop_position", position, -2);
    repeat (1200) @(negedge clk);
    check("drop_stays_idle", busy, 0);
    check("drop_position_hold", position, -2);

    // Soft travel limit on the POS_MAX=1 instance
    do_reset();
    set_rates(8'd0, 8'd0, 8'd60, 8'd0);
    en_lim = 1'b1;
    lim_rises = 0;
    lim_busy_cyc = 0;
    lim_prev = 1'b0;
    for (int i = 0; i < 2300; i++) begin
      @(negedge clk);
      if (lim_step && !lim_prev) lim_rises++;
      if (lim_busy) lim_busy_cyc++;
      lim_prev = lim_step;
    end
    check("limit_pulses", lim_rises, 1);
    check("limit_position", lim_position, 1);
    check("limit_busy_cycles", lim_busy_cyc, 60);
    check("limit_dir", lim_dir, 1);
    en_lim = 1'b0;

    // Reset asserted mid-pulse
    do_reset();
    set_rates(8'd0, 8'd0, 8'd0, 8'd25);
    enable = 1'b1;
    guard = 0;
    while (!step && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    check("rstmid_pulse_seen", step, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_step", step, 0);
    check("rstmid_position", position, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_retracting", retracting, 0);
    enable = 1'b0;
    rst = 1'b0;

    // rate_valid coincident with tick: old values evaluated first
    do_reset();
    set_rates(8'd0, 8'd0, 8'd60, 8'd0);
    enable = 1'b1;
    repeat (999) @(negedge clk);
    normal_rate = 8'd0;
    arc_rate    = 8'd0;
    open_rate   = 8'd0;
    short_rate  = 8'd25;
    rate_valid  = 1'b1;
    @(negedge clk);
    rate_valid  = 1'b0;
    wait_burst(0);
    check_burst("coinc_old", 2, 1, 105, 0);
    check("coinc_old_position", position, 2);
    wait_burst(0);
    check_burst("coinc_new", 4, 0, 205, 205);
    check("coinc_new_position", position, -2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
